// File: rtl/addsub_pkg.sv
// Shared encodings and saturation limits for the pipelined add/sub accumulator.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic SEL_A  = 1'b0;
  localparam logic SEL_Z  = 1'b1;

  // Limits are built 64 bits wide; callers cast down to their own width.
  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational N-bit signed add/sub with overflow detect and optional saturation.
// Zero latency; no flow control.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int N   = 8,
  parameter int SAT = 0
) (
  input  logic [N-1:0] p_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] r_o,
  output logic         ovf_o
);

  localparam logic [N-1:0] MAX_V = N'(sat_max(N));
  localparam logic [N-1:0] MIN_V = N'(sat_min(N));

  logic [N-1:0] raw;
  logic         same_sign;

  assign raw       = sub_i ? (p_i - b_i) : (p_i + b_i);
  assign same_sign = (p_i[N-1] == b_i[N-1]);
  // Add overflows on like signs, subtract on unlike signs, when the result flips sign.
  assign ovf_o     = (sub_i ? !same_sign : same_sign) && (raw[N-1] != p_i[N-1]);

  always_comb begin
    r_o = raw;
    if ((SAT != 0) && ovf_o) begin
      r_o = p_i[N-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/addsub_pipe_acc.sv
// Two-stage pipelined signed add/sub with accumulate, saturation option and sticky overflow.
// Latency 2 edges, one result per clock, no backpressure (consumer must take every OutValid).
module addsub_pipe_acc
  import addsub_pkg::*;
#(
  parameter int N   = 8,
  parameter int SAT = 0
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Sel,
  input  logic         AddSub,
  input  logic         InValid,
  input  logic         Clear,
  output logic [N-1:0] Z,
  output logic         Overflow,
  output logic         OutValid,
  output logic         OvfSticky
);

  logic [N-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic         sel_q, sel_d, sub_q, sub_d, v1_q, v1_d;
  logic         ovf_q, ovf_d, sticky_q, sticky_d, outv_q, outv_d;

  logic [N-1:0] p, r;
  logic         ovf;

  // Accumulate reads the Z register directly so back-to-back ops chain without a bubble.
  assign p = (sel_q == SEL_A) ? a_q : z_q;

  addsub_core #(.N(N), .SAT(SAT)) u_core (
    .p_i   (p),
    .b_i   (b_q),
    .sub_i (sub_q == OP_SUB),
    .r_o   (r),
    .ovf_o (ovf)
  );

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    sub_d    = sub_q;
    v1_d     = InValid;
    z_d      = z_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    outv_d   = 1'b0;
    if (InValid) begin
      a_d   = A;
      b_d   = B;
      sel_d = Sel;
      sub_d = AddSub;
    end
    if (v1_q) begin
      z_d      = r;
      ovf_d    = ovf;
      sticky_d = sticky_q | ovf;
      outv_d   = 1'b1;
    end
    // Clear flushes stage 1 and discards any result completing this cycle.
    if (Clear) begin
      v1_d     = 1'b0;
      z_d      = '0;
      ovf_d    = 1'b0;
      sticky_d = 1'b0;
      outv_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 1'b0;
      sub_q    <= 1'b0;
      v1_q     <= 1'b0;
      z_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      outv_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      sub_q    <= sub_d;
      v1_q     <= v1_d;
      z_q      <= z_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      outv_q   <= outv_d;
    end
  end

  assign Z         = z_q;
  assign Overflow  = ovf_q;
  assign OutValid  = outv_q;
  assign OvfSticky = sticky_q;

endmodule
